// File: rtl/video_wr_arbiter.sv
// Round-robin write-burst arbiter for NUM_CH camera channels with per-channel frame-buffer addressing.
// Define VIDEO_ARB_CH0_PRIORITY_EN to give channel 0 strict priority over the round-robin group.
module video_wr_arbiter #(
  parameter int                    NUM_CH        = 3,
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    BURST_LEN     = 16,
  parameter int                    DATA_BYTES    = 16,
  parameter int                    FRAME_BUF_NUM = 2,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = 32'h1000_0000,
  parameter logic [ADDR_WIDTH-1:0] CH_STRIDE     = 32'h0100_0000,
  parameter logic [ADDR_WIDTH-1:0] FRAME_STRIDE  = 32'h0080_0000
) (
  input  logic                                       M_AXI_ACLK,
  input  logic                                       M_AXI_ARESETN,
  input  logic [NUM_CH-1:0]                          ch_req,
  input  logic [NUM_CH-1:0]                          ch_frame_start,
  output logic [NUM_CH-1:0]                          ch_grant,
  output logic                                       wr_start,
  output logic [ADDR_WIDTH-1:0]                      wr_addr,
  input  logic                                       wr_done,
  input  logic [1:0]                                 wr_resp,
  output logic [NUM_CH*$clog2(FRAME_BUF_NUM)-1:0]    ch_rd_frame,
  output logic [NUM_CH-1:0]                          ch_ovf,
  output logic                                       err,
  output logic [1:0]                                 dbg_state
);

  localparam int FB_W        = $clog2(FRAME_BUF_NUM);
  localparam int CH_W        = $clog2(NUM_CH);
  localparam int BURST_BYTES = BURST_LEN * DATA_BYTES;
  localparam int BPF         = int'(FRAME_STRIDE / ADDR_WIDTH'(BURST_BYTES));
  localparam int CNT_W       = $clog2(BPF) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CH_W-1:0]       win_q, win_d, rr_ptr, idx;
  logic                  found, any_elig, done_now;
  logic [NUM_CH-1:0]     elig, busy, apply_fs, inc, set_pend, pend;
  logic [FB_W-1:0]       wr_frame  [NUM_CH];
  logic [CNT_W-1:0]      burst_cnt [NUM_CH];
  logic [FB_W-1:0]       addr_frame;
  logic [CNT_W-1:0]      addr_cnt;
  logic [ADDR_WIDTH-1:0] addr_d;

  assign dbg_state = state;

  // Winner search starts one past the last granted channel and wraps.
  always_comb begin
    elig     = ch_req & ~ch_ovf;
    any_elig = |elig;
    win_d    = rr_ptr;
    found    = 1'b0;
    idx      = rr_ptr;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (idx == CH_W'(NUM_CH - 1)) ? '0 : idx + CH_W'(1);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win_d = idx;
      end
    end
`ifdef VIDEO_ARB_CH0_PRIORITY_EN
    if (elig[0]) win_d = '0;
`endif
  end

  // A frame start arriving in the same cycle as the win already targets the new buffer.
  always_comb begin
    addr_frame = wr_frame[win_d] + (ch_frame_start[win_d] ? FB_W'(1) : FB_W'(0));
    addr_cnt   = ch_frame_start[win_d] ? '0 : burst_cnt[win_d];
    addr_d     = BASE_ADDR
               + ADDR_WIDTH'(win_d) * CH_STRIDE
               + ADDR_WIDTH'(addr_frame) * FRAME_STRIDE
               + ADDR_WIDTH'(addr_cnt) * ADDR_WIDTH'(BURST_BYTES);
  end

  // Frame starts on the channel owning the bus are deferred to its wr_done.
  always_comb begin
    done_now = (state == S_WAIT) && wr_done;
    busy     = '0;
    apply_fs = '0;
    inc      = '0;
    set_pend = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      busy[i]     = (state != S_IDLE) && (win_q == CH_W'(i));
      apply_fs[i] = busy[i] ? (done_now && (pend[i] || ch_frame_start[i])) : ch_frame_start[i];
      inc[i]      = busy[i] && done_now && !(pend[i] || ch_frame_start[i]);
      set_pend[i] = busy[i] && !done_now && ch_frame_start[i];
    end
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) state <= S_IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ch_grant  = '0;
    wr_start  = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_elig) state_nxt = S_GRANT;
      end
      S_GRANT: begin
        ch_grant[win_q] = 1'b1;
        wr_start        = 1'b1;
        state_nxt       = S_WAIT;
      end
      S_WAIT: begin
        ch_grant[win_q] = 1'b1;
        if (wr_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      win_q       <= '0;
      rr_ptr      <= '0;
      wr_addr     <= '0;
      err         <= 1'b0;
      ch_ovf      <= '0;
      pend        <= '0;
      ch_rd_frame <= '1;
      for (int i = 0; i < NUM_CH; i++) begin
        wr_frame[i]  <= '0;
        burst_cnt[i] <= '0;
      end
    end else begin
      if (state == S_IDLE && any_elig) begin
        win_q   <= win_d;
        wr_addr <= addr_d;
      end
      if (done_now) begin
        rr_ptr <= win_q;
        if (wr_resp != 2'b00) err <= 1'b1;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (apply_fs[i]) begin
          ch_rd_frame[i*FB_W +: FB_W] <= wr_frame[i];
          wr_frame[i]                 <= wr_frame[i] + FB_W'(1);
          burst_cnt[i]                <= '0;
          ch_ovf[i]                   <= 1'b0;
          pend[i]                     <= 1'b0;
        end else if (inc[i]) begin
          burst_cnt[i] <= burst_cnt[i] + CNT_W'(1);
          if (burst_cnt[i] + CNT_W'(1) == CNT_W'(BPF)) ch_ovf[i] <= 1'b1;
        end
        if (set_pend[i]) pend[i] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_video_wr_arbiter.sv
// Directed bench for video_wr_arbiter: default instance plus a 4-bursts-per-frame instance for overflow.
module tb_video_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req1, fs1, req2, fs2;
  logic        done1, done2;
  logic [1:0]  resp1, resp2;
  logic [2:0]  grant1, grant2, rdf1, rdf2, ovf1, ovf2;
  logic        start1, start2, err1, err2;
  logic [31:0] addr1, addr2;
  logic [1:0]  st1, st2;

  int          n_chk = 0, n_pass = 0, n_fail = 0;
  int          sel = 0;
  int          cyc;
  logic [2:0]  eg [6];
  logic [31:0] ea [6];

  logic        o_start;
  logic [2:0]  o_grant;
  logic [31:0] o_addr;
  assign o_start = (sel != 0) ? start2 : start1;
  assign o_grant = (sel != 0) ? grant2 : grant1;
  assign o_addr  = (sel != 0) ? addr2  : addr1;

  always #5 clk = ~clk;

  video_wr_arbiter u_dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .ch_req(req1), .ch_frame_start(fs1),
    .ch_grant(grant1), .wr_start(start1), .wr_addr(addr1), .wr_done(done1), .wr_resp(resp1),
    .ch_rd_frame(rdf1), .ch_ovf(ovf1), .err(err1), .dbg_state(st1)
  );

  video_wr_arbiter #(.FRAME_STRIDE(32'h400)) u_ovf (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .ch_req(req2), .ch_frame_start(fs2),
    .ch_grant(grant2), .wr_start(start2), .wr_addr(addr2), .wr_done(done2), .wr_resp(resp2),
    .ch_rd_frame(rdf2), .ch_ovf(ovf2), .err(err2), .dbg_state(st2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input int lim, output int c);
    c = 0;
    for (int k = 1; k <= lim; k++) begin
      @(negedge clk);
      if (o_start) begin
        c = k;
        break;
      end
    end
  endtask

  task automatic set_done(input logic [1:0] r);
    if (sel != 0) begin done2 = 1'b1; resp2 = r; end
    else          begin done1 = 1'b1; resp1 = r; end
    @(negedge clk);
    done1 = 1'b0; done2 = 1'b0; resp1 = 2'b00; resp2 = 2'b00;
  endtask

  task automatic do_burst(input string tag, input logic [2:0] g, input logic [31:0] a,
                          input logic [1:0] r, output int c);
    wait_start(20, c);
    chk({tag, "_start"}, 64'(c != 0), 64'd1);
    chk({tag, "_grant"}, 64'(o_grant), 64'(g));
    chk({tag, "_addr"}, 64'(o_addr), 64'(a));
    repeat (4) @(negedge clk);
    chk({tag, "_hold"}, 64'({o_grant, o_addr}), 64'({g, a}));
    set_done(r);
    chk({tag, "_release"}, 64'(o_grant), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req1 = '0; fs1 = '0; done1 = 1'b0; resp1 = 2'b00;
    req2 = '0; fs2 = '0; done2 = 1'b0; resp2 = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_grant"}, 64'(grant1), 64'd0);
    chk({tag, "_start"}, 64'(start1), 64'd0);
    chk({tag, "_addr"}, 64'(addr1), 64'd0);
    chk({tag, "_rdframe"}, 64'(rdf1), 64'h7);
    chk({tag, "_ovf"}, 64'(ovf1), 64'd0);
    chk({tag, "_err"}, 64'(err1), 64'd0);
    chk({tag, "_state"}, 64'(st1), 64'd0);
  endtask

  initial begin
    // Reset values on both instances.
    do_reset();
    chk_reset("rst");
    chk("rst_ovf_rdframe", 64'(rdf2), 64'h7);
    chk("rst_ovf_ovf", 64'(ovf2), 64'd0);

    // Single requester on channel 1; wr_start one cycle after IDLE sees the request.
    req1 = 3'b010;
    do_burst("t1_b0", 3'b010, 32'h1100_0000, 2'b00, cyc);
    chk("t1_latency", 64'(cyc), 64'd1);
    do_burst("t1_b1", 3'b010, 32'h1100_0100, 2'b00, cyc);
    req1 = 3'b000;

    // All channels requesting; the previous grant was channel 1.
`ifdef VIDEO_ARB_CH0_PRIORITY_EN
    for (int i = 0; i < 6; i++) begin
      eg[i] = 3'b001;
      ea[i] = 32'h1000_0000 + 32'(i) * 32'h100;
    end
`else
    eg[0] = 3'b100; ea[0] = 32'h1200_0000;
    eg[1] = 3'b001; ea[1] = 32'h1000_0000;
    eg[2] = 3'b010; ea[2] = 32'h1100_0200;
    eg[3] = 3'b100; ea[3] = 32'h1200_0100;
    eg[4] = 3'b001; ea[4] = 32'h1000_0100;
    eg[5] = 3'b010; ea[5] = 32'h1100_0300;
`endif
    req1 = 3'b111;
    for (int i = 0; i < 6; i++) do_burst($sformatf("t2_b%0d", i), eg[i], ea[i], 2'b00, cyc);
    req1 = 3'b000;

    // Frame rotation while idle.
    do_reset();
    req1 = 3'b001;
    do_burst("t3_b0", 3'b001, 32'h1000_0000, 2'b00, cyc);
    do_burst("t3_b1", 3'b001, 32'h1000_0100, 2'b00, cyc);
    req1 = 3'b000;
    fs1 = 3'b001;
    @(negedge clk);
    fs1 = 3'b000;
    chk("t3_rdframe0", 64'(rdf1), 64'h6);
    req1 = 3'b001;
    do_burst("t3_b2", 3'b001, 32'h1080_0000, 2'b00, cyc);
    req1 = 3'b000;
    fs1 = 3'b001;
    @(negedge clk);
    fs1 = 3'b000;
    chk("t3_rdframe1", 64'(rdf1), 64'h7);
    req1 = 3'b001;
    do_burst("t3_b3", 3'b001, 32'h1000_0000, 2'b00, cyc);

    // Frame start during WAIT is deferred until wr_done.
    wait_start(20, cyc);
    chk("t4_start", 64'(cyc != 0), 64'd1);
    chk("t4_addr", 64'(addr1), 64'h1000_0100);
    @(negedge clk);
    fs1 = 3'b001;
    @(negedge clk);
    fs1 = 3'b000;
    chk("t4_addr_held", 64'(addr1), 64'h1000_0100);
    chk("t4_rdframe_pending", 64'(rdf1), 64'h7);
    set_done(2'b00);
    chk("t4_rdframe_applied", 64'(rdf1), 64'h6);
    chk("t4_release", 64'(grant1), 64'd0);
    do_burst("t4_next", 3'b001, 32'h1080_0000, 2'b00, cyc);
    req1 = 3'b000;

    // Overflow on the 4-bursts-per-frame instance.
    sel = 1;
    req2 = 3'b100;
    for (int i = 0; i < 4; i++)
      do_burst($sformatf("t5_b%0d", i), 3'b100, 32'h1200_0000 + 32'(i) * 32'h100, 2'b00, cyc);
    chk("t5_ovf_set", 64'(ovf2), 64'h4);
    wait_start(10, cyc);
    chk("t5_no_fifth", 64'(cyc), 64'd0);
    fs2 = 3'b100;
    @(negedge clk);
    fs2 = 3'b000;
    chk("t5_ovf_clear", 64'(ovf2), 64'd0);
    chk("t5_rdframe", 64'(rdf2), 64'h3);
    do_burst("t5_resume", 3'b100, 32'h1200_0400, 2'b00, cyc);
    req2 = 3'b000;
    sel = 0;

    // Error response is sticky; counters still advance; reset mid-WAIT.
    do_reset();
    req1 = 3'b010;
    do_burst("t6_b0", 3'b010, 32'h1100_0000, 2'b00, cyc);
    chk("t6_err_clear", 64'(err1), 64'd0);
    do_burst("t6_b1", 3'b010, 32'h1100_0100, 2'b10, cyc);
    chk("t6_err_set", 64'(err1), 64'd1);
    do_burst("t6_b2", 3'b010, 32'h1100_0200, 2'b00, cyc);
    chk("t6_err_sticky", 64'(err1), 64'd1);
    wait_start(20, cyc);
    chk("t6_b3_start", 64'(cyc != 0), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    req1 = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset("t6_midrst");
    req1 = 3'b010;
    do_burst("t6_after", 3'b010, 32'h1100_0000, 2'b00, cyc);
    req1 = 3'b000;

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
